// File: rtl/rc_stage_param_pkg.sv
// Shared NoC route-compute definitions: flit field offsets, one-hot directions
// and the dimension-order route function used by the router stages.
package noc_rc_pkg;

    localparam int NOC_TIME_WIDTH  = 8;
    localparam int NOC_PDATA_WIDTH = 22;
    localparam int NOC_ADDR_WIDTH  = 4;
    localparam int NOC_DATASIZE    = 40;
    localparam int NOC_DST_LSB     = NOC_TIME_WIDTH + NOC_PDATA_WIDTH;
    localparam int NOC_SRC_LSB     = NOC_DST_LSB + NOC_ADDR_WIDTH;
    localparam int NOC_REQ_BIT     = 0;

    // Coordinates are zero-extended to this width so one function serves any mesh size.
    localparam int COORD_W = 16;

    typedef logic [4:0] dir_t;

    localparam dir_t DIR_PY    = 5'b00001;
    localparam dir_t DIR_PX    = 5'b00010;
    localparam dir_t DIR_NY    = 5'b00100;
    localparam dir_t DIR_NX    = 5'b01000;
    localparam dir_t DIR_LOCAL = 5'b10000;
    localparam dir_t DIR_NONE  = 5'b00000;

    typedef enum logic {
        ORDER_XY = 1'b0,
        ORDER_YX = 1'b1
    } route_order_e;

    function automatic dir_t route_compute(
        input logic [COORD_W-1:0] dst_x,
        input logic [COORD_W-1:0] dst_y,
        input logic [COORD_W-1:0] id_x,
        input logic [COORD_W-1:0] id_y,
        input route_order_e       order
    );
        dir_t x_dir;
        dir_t y_dir;
        dir_t route;
        x_dir = DIR_NONE;
        y_dir = DIR_NONE;
        if (dst_x < id_x) begin
            x_dir = DIR_NX;
        end else if (dst_x > id_x) begin
            x_dir = DIR_PX;
        end
        if (dst_y < id_y) begin
            y_dir = DIR_NY;
        end else if (dst_y > id_y) begin
            y_dir = DIR_PY;
        end
        if (order == ORDER_XY) begin
            route = (x_dir != DIR_NONE) ? x_dir : ((y_dir != DIR_NONE) ? y_dir : DIR_LOCAL);
        end else begin
            route = (y_dir != DIR_NONE) ? y_dir : ((x_dir != DIR_NONE) ? x_dir : DIR_LOCAL);
        end
        return route;
    endfunction

endpackage

// File: rtl/rc_stage_param_if.sv
// Bus bundle of the route-compute stage: upstream flit handshake, switch-side
// head flit handshake, downstream request-FIFO strobe/full and status outputs.
interface rc_stage_param_if #(
    parameter int DATASIZE = 40,
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int DEPTH    = 4
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic [X_W+Y_W-1:0]  ID;
    logic [DATASIZE-1:0] data_in;
    logic                valid_in;
    logic                in_ready;
    logic [DATASIZE-1:0] data_out;
    logic                valid_out;
    logic                out_ready;
    logic [4:0]          direction_out;
    logic                infifo_winc;
    logic                infifo_wfull;
    logic                drop_pulse;
    logic [OCC_W-1:0]    occupancy;

    modport master (
        output ID, data_in, valid_in, out_ready, infifo_wfull,
        input  in_ready, data_out, valid_out, direction_out, infifo_winc, drop_pulse, occupancy
    );

    modport slave (
        input  ID, data_in, valid_in, out_ready, infifo_wfull,
        output in_ready, data_out, valid_out, direction_out, infifo_winc, drop_pulse, occupancy
    );

endinterface

// File: rtl/rc_route_calc.sv
// Combinational dimension-order route from (dst, ID) to a one-hot direction.
// Defining RC_YX_ROUTE_EN selects YX order; the default build routes XY.
module rc_route_calc
    import noc_rc_pkg::*;
#(
    parameter int X_W = 2,
    parameter int Y_W = 2
) (
    input  logic [X_W+Y_W-1:0] dst_i,
    input  logic [X_W+Y_W-1:0] id_i,
    output dir_t               route_o
);

`ifdef RC_YX_ROUTE_EN
    localparam route_order_e ORDER = ORDER_YX;
`else
    localparam route_order_e ORDER = ORDER_XY;
`endif

    assign route_o = route_compute(
        COORD_W'(dst_i[X_W-1:0]),
        COORD_W'(dst_i[X_W+Y_W-1:X_W]),
        COORD_W'(id_i[X_W-1:0]),
        COORD_W'(id_i[X_W+Y_W-1:X_W]),
        ORDER
    );

endmodule

// File: rtl/rc_stage_param.sv
// Route-compute stage: DEPTH-entry flit buffer with route stored at enqueue,
// self-addressed drop and request-FIFO gating. Route order via RC_YX_ROUTE_EN.
module rc_stage_param
    import noc_rc_pkg::*;
#(
    parameter int DATASIZE = NOC_DATASIZE,
    parameter int X_W      = 2,
    parameter int Y_W      = 2,
    parameter int DST_LSB  = NOC_DST_LSB,
    parameter int SRC_LSB  = NOC_SRC_LSB,
    parameter int DEPTH    = 4
) (
    input logic             rc_clk,
    input logic             rst_n,
    rc_stage_param_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int OCC_W = AW + 1;
    localparam int ID_W  = X_W + Y_W;

    logic [DATASIZE-1:0] mem_q   [DEPTH];
    dir_t                route_q [DEPTH];
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    count_q,  count_d;
    logic                drop_q,   drop_d;

    logic [ID_W-1:0]     dst, src;
    dir_t                enq_route;
    logic [DATASIZE-1:0] head_data;
    dir_t                head_route;
    logic                full, empty, head_blocked, head_valid;
    logic                enq, self_addr, store, deq;

    assign dst = bus.data_in[DST_LSB +: ID_W];
    assign src = bus.data_in[SRC_LSB +: ID_W];

    rc_route_calc #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_route_calc (
        .dst_i   (dst),
        .id_i    (bus.ID),
        .route_o (enq_route)
    );

    assign full         = (count_q == OCC_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign head_data    = mem_q[rd_ptr_q];
    assign head_route   = route_q[rd_ptr_q];
    // A request at the head waits for FIFO space and blocks everything behind it.
    assign head_blocked = head_data[NOC_REQ_BIT] && bus.infifo_wfull;
    assign head_valid   = !empty && !head_blocked;

    assign enq       = bus.valid_in && !full;
    assign self_addr = (src == dst);
    assign store     = enq && !self_addr;
    assign deq       = head_valid && bus.out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = enq && self_addr;
        if (store) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (store && !deq) begin
            count_d = count_q + OCC_W'(1);
        end else if (!store && deq) begin
            count_d = count_q - OCC_W'(1);
        end
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i]   <= '0;
                route_q[i] <= DIR_NONE;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            if (store) begin
                mem_q[wr_ptr_q]   <= bus.data_in;
                route_q[wr_ptr_q] <= enq_route;
            end
        end
    end

    assign bus.in_ready      = !full;
    assign bus.data_out      = head_data;
    assign bus.valid_out     = head_valid;
    assign bus.direction_out = head_valid ? head_route : DIR_NONE;
    assign bus.infifo_winc   = deq && head_data[NOC_REQ_BIT];
    assign bus.drop_pulse    = drop_q;
    assign bus.occupancy     = count_q;

endmodule

// File: tb/tb_rc_stage_param.sv
// Scoreboard bench for rc_stage_param: stimulus pushes expected head flits,
// a negedge monitor pops and compares on each switch-side transfer.
module tb_rc_stage_param;
    import noc_rc_pkg::*;

    localparam int DATASIZE = 40;
    localparam int X_W      = 2;
    localparam int Y_W      = 2;
    localparam int DEPTH    = 4;

    typedef struct packed {
        logic [DATASIZE-1:0] data;
        logic [4:0]          dir;
        logic                winc;
    } exp_t;

    logic rc_clk = 1'b0;
    logic rst_n  = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    exp_t monExp;

    rc_stage_param_if #(
        .DATASIZE (DATASIZE), .X_W (X_W), .Y_W (Y_W), .DEPTH (DEPTH)
    ) bus ();

    rc_stage_param #(
        .DATASIZE (DATASIZE), .X_W (X_W), .Y_W (Y_W),
        .DST_LSB  (NOC_DST_LSB), .SRC_LSB (NOC_SRC_LSB), .DEPTH (DEPTH)
    ) dut (
        .rc_clk (rc_clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    always #5 rc_clk = ~rc_clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [DATASIZE-1:0] mkFlit(input logic [3:0] src, input logic [3:0] dst,
                                                  input logic [7:0] tag, input logic req);
        logic [DATASIZE-1:0] f;
        f = '0;
        f[NOC_SRC_LSB +: 4] = src;
        f[NOC_DST_LSB +: 4] = dst;
        f[15:8]             = tag;
        f[0]                = req;
        return f;
    endfunction

    task automatic tick();
        @(posedge rc_clk);
        #1;
    endtask

    // Hold valid_in until in_ready is seen, queueing the expected head flit unless it is self-addressed.
    task automatic applyStimulus(input logic [DATASIZE-1:0] flit, input logic [4:0] expDir);
        bit accepted;
        accepted      = 1'b0;
        bus.data_in   = flit;
        bus.valid_in  = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge rc_clk);
            if (bus.in_ready) accepted = 1'b1;
        end
        if (accepted) begin
            if (flit[NOC_SRC_LSB +: 4] != flit[NOC_DST_LSB +: 4]) begin
                expQ.push_back(exp_t'{flit, expDir, flit[0]});
            end
            @(posedge rc_clk);
            #1;
        end else begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout: got in_ready=0, expected 1 within 50 cycles");
        end
        bus.valid_in = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            if (expQ.size() == 0 && bus.occupancy == 0) done = 1'b1;
            else tick();
        end
        checkOutput({name, "_drain"}, {63'd0, done}, 64'd1);
    endtask

    task automatic checkResetValues(input string name);
        checkOutput({name, "_occupancy"}, 64'(bus.occupancy), 64'd0);
        checkOutput({name, "_valid_out"}, 64'(bus.valid_out), 64'd0);
        checkOutput({name, "_direction"}, 64'(bus.direction_out), 64'd0);
        checkOutput({name, "_data_out"}, 64'(bus.data_out), 64'd0);
        checkOutput({name, "_winc"}, 64'(bus.infifo_winc), 64'd0);
        checkOutput({name, "_drop"}, 64'(bus.drop_pulse), 64'd0);
        checkOutput({name, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    endtask

    always @(negedge rc_clk) begin
        if (rst_n) begin
            if (bus.valid_out && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_out: got data %0h, expected no transfer", bus.data_out);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("mon_data", 64'(bus.data_out), 64'(monExp.data));
                    checkOutput("mon_dir", 64'(bus.direction_out), 64'(monExp.dir));
                    checkOutput("mon_winc", 64'(bus.infifo_winc), 64'(monExp.winc));
                end
            end else begin
                checkOutput("mon_idle_winc", 64'(bus.infifo_winc), 64'd0);
                if (!bus.valid_out) checkOutput("mon_idle_dir", 64'(bus.direction_out), 64'd0);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish, expected finish before 100us");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [4:0] yxDir;
`ifdef RC_YX_ROUTE_EN
        yxDir = DIR_NY;
`else
        yxDir = DIR_PX;
`endif
        bus.ID           = 4'b0101;
        bus.data_in      = '0;
        bus.valid_in     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.infifo_wfull = 1'b0;
        #2;
        checkResetValues("por");
        #10;
        rst_n = 1'b1;
        tick();

        // Single response flit, east of this router.
        bus.out_ready = 1'b1;
        applyStimulus(mkFlit(4'h0, 4'h7, 8'h11, 1'b0), DIR_PX);
        checkOutput("t1_valid_out", 64'(bus.valid_out), 64'd1);
        checkOutput("t1_occupancy", 64'(bus.occupancy), 64'd1);
        waitDrain("t1");

        // Fill while the switch stalls, then drain in order.
        bus.out_ready = 1'b0;
        applyStimulus(mkFlit(4'h0, 4'h4, 8'h21, 1'b0), DIR_NX);
        applyStimulus(mkFlit(4'h0, 4'hD, 8'h22, 1'b0), DIR_PY);
        applyStimulus(mkFlit(4'h0, 4'h1, 8'h23, 1'b0), DIR_NY);
        applyStimulus(mkFlit(4'h0, 4'h5, 8'h24, 1'b0), DIR_LOCAL);
        checkOutput("t2_in_ready_full", 64'(bus.in_ready), 64'd0);
        checkOutput("t2_occupancy_full", 64'(bus.occupancy), 64'd4);
        tick();
        checkOutput("t2_occupancy_hold", 64'(bus.occupancy), 64'd4);
        bus.out_ready = 1'b1;
        tick();
        checkOutput("t2_in_ready_after_deq", 64'(bus.in_ready), 64'd1);
        checkOutput("t2_occupancy_after_deq", 64'(bus.occupancy), 64'd3);
        waitDrain("t2");

        // Request flit held by a full downstream FIFO, released combinationally.
        bus.infifo_wfull = 1'b1;
        applyStimulus(mkFlit(4'h0, 4'h7, 8'h31, 1'b1), DIR_PX);
        checkOutput("t3_blocked_valid", 64'(bus.valid_out), 64'd0);
        checkOutput("t3_blocked_winc", 64'(bus.infifo_winc), 64'd0);
        checkOutput("t3_blocked_occ", 64'(bus.occupancy), 64'd1);
        tick();
        checkOutput("t3_still_blocked", 64'(bus.valid_out), 64'd0);
        bus.infifo_wfull = 1'b0;
        #1;
        checkOutput("t3_release_valid", 64'(bus.valid_out), 64'd1);
        checkOutput("t3_release_winc", 64'(bus.infifo_winc), 64'd1);
        tick();
        checkOutput("t3_winc_single", 64'(bus.infifo_winc), 64'd0);
        checkOutput("t3_occupancy", 64'(bus.occupancy), 64'd0);

        // Self-addressed flit is dropped.
        applyStimulus(mkFlit(4'h5, 4'h5, 8'h41, 1'b0), DIR_LOCAL);
        checkOutput("t4_drop_pulse", 64'(bus.drop_pulse), 64'd1);
        checkOutput("t4_occupancy", 64'(bus.occupancy), 64'd0);
        checkOutput("t4_valid_out", 64'(bus.valid_out), 64'd0);
        tick();
        checkOutput("t4_drop_cleared", 64'(bus.drop_pulse), 64'd0);

        // Diagonal route depends on dimension order; back-to-back enqueue/dequeue keeps occupancy.
        applyStimulus(mkFlit(4'h0, 4'h2, 8'h51, 1'b0), yxDir);
        applyStimulus(mkFlit(4'h3, 4'h5, 8'h52, 1'b0), DIR_LOCAL);
        checkOutput("t5_occ_stream", 64'(bus.occupancy), 64'd1);
        waitDrain("t5");

        // Asynchronous reset in the middle of traffic.
        bus.out_ready = 1'b0;
        applyStimulus(mkFlit(4'h0, 4'h7, 8'h61, 1'b0), DIR_PX);
        applyStimulus(mkFlit(4'h0, 4'h7, 8'h62, 1'b0), DIR_PX);
        applyStimulus(mkFlit(4'h0, 4'h7, 8'h63, 1'b0), DIR_PX);
        checkOutput("t6_occ_before", 64'(bus.occupancy), 64'd3);
        checkOutput("t6_valid_before", 64'(bus.valid_out), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("t6_reset");
        expQ.delete();
        #10;
        rst_n = 1'b1;
        tick();
        checkOutput("t6_in_ready_after", 64'(bus.in_ready), 64'd1);
        checkOutput("t6_occ_after", 64'(bus.occupancy), 64'd0);
        checkOutput("t6_valid_after", 64'(bus.valid_out), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rc_stage_param.md
Name: rc_stage_param

Overview:
Parametrised route-compute stage for the mesh NoC router. It sits between the input port buffer and the switch allocator and replaces the fixed 4x4 route-compute block. It buffers DEPTH flits, computes dimension-order routes for an X_W/Y_W-sized mesh at enqueue, and drops self-addressed flits. It also gates request flits against the downstream request-FIFO full flag using a proper valid/ready handshake.

Parameters:
DATASIZE, 40, flit width in bits.
X_W, 2, width of the X coordinate; ID[X_W-1:0] holds X.
Y_W, 2, width of the Y coordinate; ID[X_W+Y_W-1:X_W] holds Y.
DST_LSB, 30, LSB of the dst field in a flit (TIME_WIDTH+PDATA_WIDTH).
SRC_LSB, 34, LSB of the src field in a flit (DST_LSB+ADDR_WIDTH).
DEPTH, 4, buffer entries; power of two, at least 2.

Ports:
rc_clk  input  1  the single clock; all state is on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
ID  input  X_W+Y_W  router coordinate; quasi-static.
data_in  input  DATASIZE  incoming flit; bit0=1 marks a request flit.
valid_in  input  1  flit valid.
in_ready  output  1  the stage can accept a flit.
data_out  output  DATASIZE  head flit.
valid_out  output  1  head flit valid for the switch.
out_ready  input  1  switch accepts the head flit.
direction_out  output  5  one-hot route: [0] +Y, [1] +X, [2] -Y, [3] -X, [4] local.
infifo_winc  output  1  write strobe for the downstream request FIFO.
infifo_wfull  input  1  the downstream request FIFO is full.
drop_pulse  output  1  one-cycle pulse when a self-addressed flit is dropped.
occupancy  output  $clog2(DEPTH)+1  number of stored flits.

Behaviour:
- Reset values: occupancy=0, valid_out=0, direction_out=0, data_out=0, infifo_winc=0, drop_pulse=0, in_ready=1. Reset clears storage and pointers immediately, including mid-transfer; any in-flight flit is lost.
- Enqueue fires when valid_in && in_ready. in_ready = (occupancy != DEPTH), with no same-cycle pass-through when full.
- Self-addressed flits: if src==dst on an accepted flit, the flit is not stored. drop_pulse is registered and goes high in cycle N+1 for an acceptance in cycle N.
- Route computation happens at enqueue, on (dst, ID), and the result is stored with the flit. Default order is XY:
  - dst.x < ID.x gives -X; dst.x > ID.x gives +X.
  - Otherwise dst.y < ID.y gives -Y; dst.y > ID.y gives +Y.
  - Otherwise the route is local.
  - All comparisons are unsigned on the X_W/Y_W slices.
- Latency: a flit accepted in cycle N appears at data_out/direction_out with valid_out in cycle N+1. data_out and direction_out are driven from the head storage register.
- valid_out = !empty && !(head[0] && infifo_wfull). A request flit at the head stalls while the FIFO is full. This is head-of-line blocking by design: response flits queued behind it also wait.
- direction_out = stored route when valid_out, else 5'b0.
- Dequeue fires when valid_out && out_ready.
- infifo_winc = valid_out && out_ready && data_out[0]. It is combinational and asserts exactly once per request flit.
- Simultaneous enqueue and dequeue:
  - When not full, occupancy is unchanged.
  - When full, only the dequeue happens; in_ready rises the next cycle.
  - A simultaneous dequeue plus drop reduces occupancy by 1.
- Pointers wrap modulo DEPTH.
- Data and route must stay stable while valid_out && !out_ready.
- infifo_wfull deasserting releases the head in the same cycle, with no extra bubble.

Optional Feature:
RC_YX_ROUTE_EN
- Defined: YX dimension order. Y is resolved first (-Y/+Y), then X, then local.
- Undefined: XY order as above.
- All other timing is identical. Selection is at compile time only.

Decomposition:
- A noc_rc_pkg holds:
  - direction one-hot localparams DIR_PY, DIR_PX, DIR_NY, DIR_NX, DIR_LOCAL, DIR_NONE.
  - the flit field-offset constants derived from noc_define widths.
  - a route-function header shared with other router stages.
- One sub-module, rc_route_calc: combinational route calculation from (dst, ID) to a 5-bit one-hot, honouring RC_YX_ROUTE_EN. It is instantiated on the enqueue path.

Test Plan:
1. ID=4'b0101, send dst x=3,y=1 response, out_ready=1 -> next cycle valid_out=1, direction_out=5'b00010, infifo_winc=0.
2. Fill with 4 flits while out_ready=0 -> in_ready=0 after the 4th acceptance, occupancy=4. Raise out_ready -> flits leave in order, one per cycle, and in_ready=1 after the first dequeue.
3. Request head (bit0=1) with infifo_wfull=1 and out_ready=1 -> valid_out=0, no infifo_winc. Drop infifo_wfull -> same cycle valid_out=1 and infifo_winc=1 for exactly 1 cycle.
4. Send src==dst=4'h5 with ID=4'h5 -> occupancy stays 0, drop_pulse=1 for one cycle, valid_out never asserts.
5. ID x=1,y=1, dst x=2,y=0 -> +X (5'b00010) without the macro, -Y (5'b00100) with RC_YX_ROUTE_EN. dst=ID delivered from another src -> 5'b10000.
6. Assert rst_n=0 with occupancy=3 and valid_out=1 -> all outputs reach reset values asynchronously. After release, in_ready=1 and occupancy=0.
